// File: rtl/store_queue_ctrl.sv
// Store-path queue: checks alignment, lane-formats accepted stores and drains them
// to the data memory over a req/ack write port, one store per cycle when memory is ready.
//
// state  | meaning
// S_IDLE | no write presented; queue empty
// S_REQ  | head entry presented on mem_*, waiting for mem_ack
`timescale 1ns/1ps
module store_queue_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic             st_sb,
  input  logic             st_sh,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  output logic             misalign,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               misalign_q;

  logic [29:0]        addr_q  [DEPTH];
  logic [31:0]        wdata_q [DEPTH];
  logic [3:0]         be_q    [DEPTH];

  logic               aligned, accept, push, pop;
  logic [3:0]         be_fmt;
  logic [31:0]        wdata_fmt;

  assign st_ready = !rst && (count_q < DEPTH_C);
  assign aligned  = st_sb || (st_sh ? !st_addr[0] : (st_addr[1:0] == 2'b00));
  assign accept   = st_valid && st_ready;
  assign push     = accept && aligned;
  assign pop      = (state_q == S_REQ) && mem_ack;

  // Lane placement is done once at enqueue so the drain side is a plain read.
  always_comb begin
    be_fmt    = 4'b0000;
    wdata_fmt = 32'h0;
    if (st_sb) begin
      be_fmt    = 4'b0001 << st_addr[1:0];
      wdata_fmt = {24'h0, st_data[7:0]} << {st_addr[1:0], 3'b000};
    end else if (st_sh) begin
      be_fmt    = 4'b0011 << {st_addr[1], 1'b0};
      wdata_fmt = {16'h0, st_data[15:0]} << {st_addr[1], 4'b0000};
    end else begin
      be_fmt    = 4'b1111;
      wdata_fmt = st_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr]  <= st_addr[31:2];
      wdata_q[wr_ptr] <= wdata_fmt;
      be_q[wr_ptr]    <= be_fmt;
    end
  end

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = (count_d != '0) ? S_REQ : S_IDLE;
      S_REQ:   if (mem_ack) state_d = (count_d != '0) ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset drops any in-flight request along with the queue contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      misalign_q <= accept && !aligned;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  assign mem_req   = (state_q == S_REQ);
  assign mem_addr  = {addr_q[rd_ptr], 2'b00};
  assign mem_wdata = wdata_q[rd_ptr];
  assign mem_be    = be_q[rd_ptr];
  assign misalign  = misalign_q;
  assign count     = count_q;
  assign empty     = (count_q == '0) && !mem_req;

endmodule

// File: tb/tb_store_queue_ctrl.sv
// Self-checking bench for store_queue_ctrl: a cycle model tracks occupancy/handshake
// and a scoreboard of lane-formatted stores is compared at every memory write.
`timescale 1ns/1ps
module tb_store_queue_ctrl;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             st_valid;
  logic             st_ready;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic             st_sb;
  logic             st_sh;
  logic             mem_req;
  logic             mem_ack;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic             misalign;
  logic [CNT_W-1:0] count;
  logic             empty;

  store_queue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_sb(st_sb), .st_sh(st_sh),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .misalign(misalign), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } entry_t;

  entry_t sb_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  bit     mon_en   = 1'b0;
  int     m_cnt    = 0;
  bit     m_req    = 1'b0;
  bit     m_mis    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_aligned(input logic [31:0] a, input logic sb, input logic sh);
    if (sb) return 1'b1;
    if (sh) return a[0] == 1'b0;
    return a[1:0] == 2'b00;
  endfunction

  function automatic entry_t fmt(input logic [31:0] a, input logic [31:0] d,
                                 input logic sb, input logic sh);
    entry_t e;
    int base, size;
    e.addr = {a[31:2], 2'b00};
    e.be = 4'b0000;
    e.wdata = 32'h0;
    if (sb) begin base = int'(a[1:0]); size = 1; end
    else if (sh) begin base = a[1] ? 2 : 0; size = 2; end
    else begin base = 0; size = 4; end
    for (int i = 0; i < size; i++) begin
      e.be[base + i] = 1'b1;
      e.wdata[(base + i) * 8 +: 8] = d[i * 8 +: 8];
    end
    return e;
  endfunction

  // Model + scoreboard: inputs are stable at the falling edge, so it sees what the next rising edge will
  always @(negedge clk) begin
    if (mon_en) begin
      bit m_ready, ok, push, pop;
      entry_t e;
      m_ready = !rst && (m_cnt < DEPTH);
      ok      = is_aligned(st_addr, st_sb, st_sh);
      push    = st_valid && m_ready && ok;
      pop     = m_req && mem_ack && !rst;
      check("st_ready", 32'(st_ready), 32'(m_ready));
      check("count", 32'(count), 32'(m_cnt));
      check("mem_req", 32'(mem_req), 32'(m_req));
      check("empty", 32'(empty), 32'((m_cnt == 0) && !m_req));
      check("misalign", 32'(misalign), 32'(m_mis));
      if (pop) begin
        if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          check("mem_addr", mem_addr, e.addr);
          check("mem_be", 32'(mem_be), 32'(e.be));
          check("mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (rst) begin
        m_cnt = 0; m_req = 1'b0; m_mis = 1'b0;
        sb_q.delete();
      end else begin
        m_cnt = m_cnt + int'(push) - int'(pop);
        m_req = (m_cnt != 0);
        m_mis = st_valid && m_ready && !ok;
        if (push) sb_q.push_back(fmt(st_addr, st_data, st_sb, st_sh));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_st(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic sb, input logic sh);
    st_valid = v; st_addr = a; st_data = d; st_sb = sb; st_sh = sh;
  endtask

  task automatic drain(input int cycles);
    st_valid = 1'b0;
    mem_ack  = 1'b1;
    repeat (cycles) tick();
    mem_ack  = 1'b0;
    check("drained_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0;
    set_st(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    mon_en = 1'b1;
    check("rst_ready_low", 32'(st_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_empty", 32'(empty), 32'd1);

    // byte store into the top lane
    set_st(1'b1, 32'h1003, 32'hAB, 1'b1, 1'b0);
    tick();
    st_valid = 1'b0;
    check("t1_req", 32'(mem_req), 32'd1);
    check("t1_addr", mem_addr, 32'h1000);
    check("t1_be", 32'(mem_be), 32'h8);
    check("t1_wdata", mem_wdata, 32'hAB00_0000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t1_req_done", 32'(mem_req), 32'd0);
    check("t1_empty", 32'(empty), 32'd1);

    // back-to-back half then word with zero-wait memory
    mem_ack = 1'b1;
    set_st(1'b1, 32'h2002, 32'h1234, 1'b0, 1'b1);
    tick();
    check("t2_addr0", mem_addr, 32'h2000);
    check("t2_be0", 32'(mem_be), 32'hC);
    check("t2_wdata0", mem_wdata, 32'h1234_0000);
    set_st(1'b1, 32'h2004, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    st_valid = 1'b0;
    check("t2_req1", 32'(mem_req), 32'd1);
    check("t2_addr1", mem_addr, 32'h2004);
    check("t2_be1", 32'(mem_be), 32'hF);
    check("t2_wdata1", mem_wdata, 32'hDEAD_BEEF);
    tick();
    mem_ack = 1'b0;
    check("t2_idle", 32'(mem_req), 32'd0);

    // fill to full with ack low, then one ack while the fifth store is held
    for (int i = 0; i < 4; i++) begin
      set_st(1'b1, 32'h4000 + 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    set_st(1'b1, 32'h4010, 32'h1004, 1'b0, 1'b0);
    check("t3_full_cnt", 32'(count), 32'd4);
    check("t3_full_ready", 32'(st_ready), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t3_cnt_after_ack", 32'(count), 32'd3);
    check("t3_ready_after_ack", 32'(st_ready), 32'd1);
    tick();
    st_valid = 1'b0;
    check("t3_cnt_refill", 32'(count), 32'd4);
    drain(6);

    // misaligned half then word
    set_st(1'b1, 32'h3001, 32'h5555, 1'b0, 1'b1);
    tick();
    check("t4_mis_h", 32'(misalign), 32'd1);
    set_st(1'b1, 32'h3002, 32'h6666, 1'b0, 1'b0);
    tick();
    st_valid = 1'b0;
    check("t4_mis_w", 32'(misalign), 32'd1);
    check("t4_cnt", 32'(count), 32'd0);
    tick();
    check("t4_mis_clear", 32'(misalign), 32'd0);
    check("t4_no_req", 32'(mem_req), 32'd0);

    // reset with three entries and an in-flight request
    for (int i = 0; i < 3; i++) begin
      set_st(1'b1, 32'h6000 + 32'(i * 4), 32'h60 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    st_valid = 1'b0;
    check("t5_pre_cnt", 32'(count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_req", 32'(mem_req), 32'd0);
    check("t5_cnt", 32'(count), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    set_st(1'b1, 32'h5001, 32'h77, 1'b1, 1'b0);
    tick();
    st_valid = 1'b0;
    check("t5_be", 32'(mem_be), 32'h2);
    check("t5_wdata", mem_wdata, 32'h0000_7700);
    drain(3);

    // random traffic with random memory stalls
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      set_st(1'($urandom_range(0, 1)), $urandom, $urandom, kind == 0, kind == 1);
      mem_ack = 1'($urandom_range(0, 2) != 0);
      tick();
    end
    drain(DEPTH + 3);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
